// File: rtl/ibex_alu_iter.sv
// Parametrised-width ALU with an iterative shifter/rotator.
// Add/logic/compare ops and zero-amount shifts complete at the accept edge.
// Shifts and rotates by a non-zero amount advance ShiftStep bits per cycle.
module ibex_alu_iter #(
  parameter int unsigned Width     = 32,
  parameter int unsigned ShiftStep = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       operator_i,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [Width-1:0] result_o,
  output logic             comparison_result_o,
  output logic             busy_o
);

  localparam int unsigned AW = $clog2(Width);
  localparam logic [AW:0] WIDTH_C = (AW+1)'(Width);
  localparam logic [AW:0] STEP_C  = (AW+1)'(ShiftStep);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_EQ   = 4'd12;
  localparam logic [3:0] OP_NE   = 4'd13;
  localparam logic [3:0] OP_GE   = 4'd14;
  localparam logic [3:0] OP_GEU  = 4'd15;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [Width-1:0] work_q;
  logic [AW-1:0]    rem_q;

  logic [AW-1:0]    amt;
  logic             is_shift_op, is_cmp_op, signed_cmp;
  logic             accept, start_shift;
  logic [Width:0]   cmp_diff;
  logic             lt, eq;
  logic [Width-1:0] res_c;
  logic             flag_c;
  logic [AW:0]      rem_ext, s, inv_s;
  logic             last_step;
  logic [Width-1:0] work_nxt;

  assign ready_o     = (state_q == IDLE);
  assign busy_o      = (state_q == SHIFT);
  assign amt         = operand_b_i[AW-1:0];
  assign is_shift_op = (operator_i >= OP_SLL) && (operator_i <= OP_ROR);
  assign is_cmp_op   = (operator_i >= OP_SLT);
  assign signed_cmp  = (operator_i == OP_SLT) || (operator_i == OP_GE);
  assign accept      = valid_i & ready_o & ~flush_i;
  assign start_shift = accept & is_shift_op & (amt != '0);

  // Single subtractor for all compares: the extension bit selects signed/unsigned.
  assign cmp_diff = {signed_cmp & operand_a_i[Width-1], operand_a_i}
                  - {signed_cmp & operand_b_i[Width-1], operand_b_i};
  assign lt = cmp_diff[Width];
  assign eq = (cmp_diff[Width-1:0] == '0);

  // Single-cycle result: arithmetic, logic, compares and zero-amount shifts.
  always_comb begin
    res_c  = '0;
    flag_c = 1'b0;
    unique case (operator_i)
      OP_ADD:  res_c = operand_a_i + operand_b_i;
      OP_SUB:  res_c = operand_a_i - operand_b_i;
      OP_XOR:  res_c = operand_a_i ^ operand_b_i;
      OP_OR:   res_c = operand_a_i | operand_b_i;
      OP_AND:  res_c = operand_a_i & operand_b_i;
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: res_c = operand_a_i;
      OP_SLT, OP_SLTU: flag_c = lt;
      OP_EQ:   flag_c = eq;
      OP_NE:   flag_c = ~eq;
      OP_GE, OP_GEU: flag_c = ~lt;
      default: res_c = '0;
    endcase
    if (is_cmp_op) res_c = {{(Width-1){1'b0}}, flag_c};
  end

  // One iteration of the shifter: advance by min(ShiftStep, remaining).
  assign rem_ext   = {1'b0, rem_q};
  assign s         = (rem_ext < STEP_C) ? rem_ext : STEP_C;
  assign inv_s     = WIDTH_C - s;
  assign last_step = (rem_ext <= STEP_C);

  always_comb begin
    work_nxt = work_q;
    unique case (op_q)
      OP_SLL:  work_nxt = work_q << s;
      OP_SRL:  work_nxt = work_q >> s;
      OP_SRA:  work_nxt = Width'($signed(work_q) >>> s);
      OP_ROL:  work_nxt = (work_q << s) | (work_q >> inv_s);
      OP_ROR:  work_nxt = (work_q >> s) | (work_q << inv_s);
      default: work_nxt = work_q;
    endcase
  end

  // Next-state logic; flush forces IDLE above everything else.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start_shift) state_d = SHIFT;
        SHIFT:   if (last_step) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Datapath: operand capture, shift iteration and registered results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q                <= OP_ADD;
      work_q              <= '0;
      rem_q               <= '0;
      valid_o             <= 1'b0;
      result_o            <= '0;
      comparison_result_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (!flush_i) begin
        if (start_shift) begin
          op_q   <= operator_i;
          work_q <= operand_a_i;
          rem_q  <= amt;
        end else if (accept) begin
          result_o            <= res_c;
          comparison_result_o <= flag_c;
          valid_o             <= 1'b1;
        end else if (state_q == SHIFT) begin
          work_q <= work_nxt;
          rem_q  <= rem_q - s[AW-1:0];
          if (last_step) begin
            result_o            <= work_nxt;
            comparison_result_o <= 1'b0;
            valid_o             <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ibex_alu_iter.sv
// Bench for ibex_alu_iter: three instances at ShiftStep 4, 1 and 32.
module tb_ibex_alu_iter;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_XOR = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8,  OP_ROR = 4'd9,  OP_SLT = 4'd10, OP_SLTU = 4'd11;
  localparam logic [3:0] OP_EQ  = 4'd12, OP_NE  = 4'd13, OP_GE  = 4'd14, OP_GEU = 4'd15;

  logic        clk, rst_n, flush;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        vi  [3];
  logic        vo  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        cmp [3];
  logic [31:0] res [3];

  int steps [3] = '{4, 1, 32};
  int errors = 0;
  int checks = 0;

  ibex_alu_iter #(.Width(32), .ShiftStep(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[0]), .ready_o(rdy[0]),
    .operator_i(op), .operand_a_i(a), .operand_b_i(b), .flush_i(flush),
    .valid_o(vo[0]), .result_o(res[0]), .comparison_result_o(cmp[0]), .busy_o(bsy[0]));

  ibex_alu_iter #(.Width(32), .ShiftStep(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[1]), .ready_o(rdy[1]),
    .operator_i(op), .operand_a_i(a), .operand_b_i(b), .flush_i(1'b0),
    .valid_o(vo[1]), .result_o(res[1]), .comparison_result_o(cmp[1]), .busy_o(bsy[1]));

  ibex_alu_iter #(.Width(32), .ShiftStep(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[2]), .ready_o(rdy[2]),
    .operator_i(op), .operand_a_i(a), .operand_b_i(b), .flush_i(1'b0),
    .valid_o(vo[2]), .result_o(res[2]), .comparison_result_o(cmp[2]), .busy_o(bsy[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cmp;
    int          lat;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference ALU from the arithmetic definitions; returns {flag, result}.
  function automatic logic [32:0] ref_alu(input logic [3:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
    int amt;
    logic [31:0] r;
    logic f;
    amt = int'(y % 32);
    r = 32'h0;
    f = 1'b0;
    case (o)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_XOR:  r = x ^ y;
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      OP_SLL:  r = x << amt;
      OP_SRL:  r = x >> amt;
      OP_SRA:  r = 32'($signed(x) >>> amt);
      OP_ROL:  r = (amt == 0) ? x : ((x << amt) | (x >> (32 - amt)));
      OP_ROR:  r = (amt == 0) ? x : ((x >> amt) | (x << (32 - amt)));
      OP_SLT:  f = ($signed(x) < $signed(y));
      OP_SLTU: f = (x < y);
      OP_EQ:   f = (x == y);
      OP_NE:   f = (x != y);
      OP_GE:   f = ($signed(x) >= $signed(y));
      default: f = (x >= y);
    endcase
    if (o >= OP_SLT) r = {31'b0, f};
    return {f, r};
  endfunction

  function automatic int ref_lat(input logic [3:0] o, input logic [31:0] y, input int step);
    int amt;
    amt = int'(y % 32);
    if (o >= OP_SLL && o <= OP_ROR && amt != 0) return 1 + (amt + step - 1) / step;
    return 1;
  endfunction

  // Present one request for a single cycle; returns at the negedge of cycle 1.
  task automatic issue(input int idx, input logic [3:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    op = o; a = x; b = y; vi[idx] = 1'b1;
    @(negedge clk);
    vi[idx] = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_valid(input int idx, input int maxc, output int lat);
    lat = 1;
    while (!vo[idx] && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input int idx, input string name, input logic [3:0] o,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic ec, input int el);
    int lat;
    issue(idx, o, x, y);
    wait_valid(idx, 40, lat);
    chk({name, "_valid"}, 32'(vo[idx]), 32'd1);
    chk({name, "_lat"}, 32'(lat), 32'(el));
    chk({name, "_res"}, res[idx], er);
    chk({name, "_cmp"}, 32'(cmp[idx]), 32'(ec));
    @(negedge clk);
    chk({name, "_pulse"}, 32'(vo[idx]), 32'd0);
  endtask

  function automatic vec_t mk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] r, input logic c, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.res = r; v.cmp = c; v.lat = l;
    return v;
  endfunction

  initial begin
    int lat, nbusy, npulse;
    logic [32:0] exp;

    tbl.push_back(mk(OP_ADD,  32'd7,          32'd8,          32'd15,         1'b0, 1));
    tbl.push_back(mk(OP_SUB,  32'd3,          32'd5,          32'hFFFFFFFE,   1'b0, 1));
    tbl.push_back(mk(OP_XOR,  32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   1'b0, 1));
    tbl.push_back(mk(OP_OR,   32'h000000F0,   32'h0000000F,   32'h000000FF,   1'b0, 1));
    tbl.push_back(mk(OP_AND,  32'h0000F0F0,   32'h00000FF0,   32'h000000F0,   1'b0, 1));
    tbl.push_back(mk(OP_SLL,  32'h1,          32'd31,         32'h80000000,   1'b0, 9));
    tbl.push_back(mk(OP_SRA,  32'h80000000,   32'd4,          32'hF8000000,   1'b0, 2));
    tbl.push_back(mk(OP_SRA,  32'h80000000,   32'd31,         32'hFFFFFFFF,   1'b0, 9));
    tbl.push_back(mk(OP_ROR,  32'h12345678,   32'd8,          32'h78123456,   1'b0, 3));
    tbl.push_back(mk(OP_ROL,  32'h12345678,   32'd4,          32'h23456781,   1'b0, 2));
    tbl.push_back(mk(OP_SRL,  32'h000000F0,   32'h21,         32'h00000078,   1'b0, 2));
    tbl.push_back(mk(OP_SLL,  32'h0000ABCD,   32'h20,         32'h0000ABCD,   1'b0, 1));
    tbl.push_back(mk(OP_SLT,  32'hFFFFFFFF,   32'd1,          32'h1,          1'b1, 1));
    tbl.push_back(mk(OP_SLTU, 32'hFFFFFFFF,   32'd1,          32'h0,          1'b0, 1));
    tbl.push_back(mk(OP_GE,   32'h80000000,   32'h7FFFFFFF,   32'h0,          1'b0, 1));
    tbl.push_back(mk(OP_GEU,  32'h80000000,   32'h7FFFFFFF,   32'h1,          1'b1, 1));
    tbl.push_back(mk(OP_EQ,   32'd5,          32'd5,          32'h1,          1'b1, 1));
    tbl.push_back(mk(OP_NE,   32'd5,          32'd6,          32'h1,          1'b1, 1));

    rst_n = 1'b0; flush = 1'b0; op = OP_ADD; a = '0; b = '0;
    for (int i = 0; i < 3; i++) vi[i] = 1'b0;
    #12;
    chk("rst_valid", 32'(vo[0]), 32'd0);
    chk("rst_res",   res[0], 32'd0);
    chk("rst_cmp",   32'(cmp[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_busy",  32'(bsy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back single-cycle ops.
    op = OP_ADD; a = 32'hFFFFFFFF; b = 32'd1; vi[0] = 1'b1;
    @(negedge clk);
    op = OP_SLTU; a = 32'd1; b = 32'd2;
    chk("b2b_v1", 32'(vo[0]), 32'd1);
    chk("b2b_r1", res[0], 32'h0);
    chk("b2b_c1", 32'(cmp[0]), 32'd0);
    @(negedge clk);
    vi[0] = 1'b0;
    chk("b2b_v2", 32'(vo[0]), 32'd1);
    chk("b2b_r2", res[0], 32'h1);
    chk("b2b_c2", 32'(cmp[0]), 32'd1);
    @(negedge clk);
    chk("b2b_idle", 32'(vo[0]), 32'd0);

    foreach (tbl[i])
      run_op(0, $sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].res, tbl[i].cmp, tbl[i].lat);

    // Long shift: busy for 8 cycles, never ready, valid in cycle 9.
    issue(0, OP_SLL, 32'h1, 32'd31);
    nbusy = 0;
    for (int c = 1; c <= 8; c++) begin
      if (bsy[0] && !rdy[0] && !vo[0]) nbusy++;
      @(negedge clk);
    end
    chk("sll31_busy_cycles", 32'(nbusy), 32'd8);
    chk("sll31_valid", 32'(vo[0]), 32'd1);
    chk("sll31_res", res[0], 32'h80000000);
    run_op(1, "sll31_step1",  OP_SLL, 32'h1, 32'd31, 32'h80000000, 1'b0, 32);
    run_op(2, "sll31_step32", OP_SLL, 32'h1, 32'd31, 32'h80000000, 1'b0, 2);

    // Flush on second SHIFT cycle.
    run_op(0, "pre_flush", OP_ADD, 32'h1234, 32'h0, 32'h1234, 1'b0, 1);
    issue(0, OP_SLL, 32'h1, 32'd16);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", 32'(rdy[0]), 32'd1);
    chk("flush_busy",  32'(bsy[0]), 32'd0);
    chk("flush_res",   res[0], 32'h1234);
    npulse = 0;
    for (int c = 0; c < 8; c++) begin
      if (vo[0]) npulse++;
      @(negedge clk);
    end
    chk("flush_no_valid", 32'(npulse), 32'd0);
    op = OP_ADD; a = 32'd9; b = 32'd9; vi[0] = 1'b1; flush = 1'b1;
    @(negedge clk);
    vi[0] = 1'b0; flush = 1'b0;
    chk("flush_accept_valid", 32'(vo[0]), 32'd0);
    chk("flush_accept_res", res[0], 32'h1234);

    // Asynchronous reset in the middle of a rotate.
    run_op(0, "pre_rst", OP_ADD, 32'h50, 32'h5, 32'h55, 1'b0, 1);
    run_op(0, "pre_rst_cmp", OP_EQ, 32'h3, 32'h3, 32'h1, 1'b1, 1);
    issue(0, OP_ROL, 32'h12345678, 32'd20);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(vo[0]), 32'd0);
    chk("arst_res",   res[0], 32'd0);
    chk("arst_cmp",   32'(cmp[0]), 32'd0);
    chk("arst_ready", 32'(rdy[0]), 32'd1);
    chk("arst_busy",  32'(bsy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(0, "post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    // Randomized ops against the reference model on every step size.
    for (int idx = 0; idx < 3; idx++) begin
      for (int n = 0; n < 60; n++) begin
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        ro = 4'($urandom_range(0, 15));
        ra = $urandom;
        rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
        if ($urandom_range(0, 7) == 0) rb = ra ^ 32'h80000000;
        exp = ref_alu(ro, ra, rb);
        run_op(idx, $sformatf("rnd_s%0d_op%0d", steps[idx], ro), ro, ra, rb,
               exp[31:0], exp[32], ref_lat(ro, rb, steps[idx]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
